dispatch_scoreboard: RTL and testbench

DISPATCH_SCOREBOARD -- requirements
Module: dispatch_scoreboard

---
 rtl/ooo_pkg.sv | 24 ++
 rtl/reg_busy_table.sv | 72 +++++++
 rtl/dispatch_scoreboard.sv | 181 ++++++++++++++++++
 tb/tb_dispatch_scoreboard.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ooo_pkg.sv
// Shared definitions for the out-of-order dispatch front end: default field
// widths, the dispatch/drain FSM encoding and a width helper.
package ooo_pkg;

    localparam int unsigned DEF_NUM_STATION = 2;
    localparam int unsigned DEF_NUM_REG     = 8;
    localparam int unsigned DEF_INST_ID_BIT = 8;
    localparam int unsigned DEF_IMM_BIT     = 4;
    localparam int unsigned STALL_CNT_BIT   = 16;

    // Dispatch FSM: RUN accepts instructions, DRAIN waits for the machine to
    // go quiet, DONE is the single cycle that reports drain completion.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } dsb_state_e;

    // $clog2 that never returns 0, so a single-entry select still has one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_busy_table.sv
// Architectural register busy table.
// A register is busy from the edge at which a writer is dispatched until the
// edge at which any functional unit reports its writeback.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   set_en       - a writer to set_reg is being dispatched this cycle
//   set_reg      - destination register of the dispatched writer
//   clr_vld      - per-writeback-port valid
//   clr_reg      - per-writeback-port register, port k at [k*REG_ID_BIT +: REG_ID_BIT]
//   busy         - current busy bits
//   err_wb_idle  - sticky: a writeback named a register that was not busy
module reg_busy_table
    import ooo_pkg::*;
#(
    parameter int unsigned NUM_REG    = DEF_NUM_REG,
    parameter int unsigned NUM_WB     = DEF_NUM_STATION,
    parameter int unsigned REG_ID_BIT = $clog2(NUM_REG)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         set_en,
    input  logic [REG_ID_BIT-1:0]        set_reg,
    input  logic [NUM_WB-1:0]            clr_vld,
    input  logic [NUM_WB*REG_ID_BIT-1:0] clr_reg,
    output logic [NUM_REG-1:0]           busy,
    output logic                         err_wb_idle
);

    logic [NUM_REG-1:0] busy_nxt_c;
    logic               idle_hit_c;

    // Next busy vector: every writeback port clears, then dispatch sets, so a
    // same-cycle set and clear of one register leaves it busy.
    always_comb begin
        busy_nxt_c = busy;
        idle_hit_c = 1'b0;
        for (int k = 0; k < int'(NUM_WB); k++) begin
            if (clr_vld[k]) begin
                if (32'(clr_reg[k*REG_ID_BIT +: REG_ID_BIT]) >= NUM_REG) begin
                    idle_hit_c = 1'b1;
                end
                for (int r = 0; r < int'(NUM_REG); r++) begin
                    if (clr_reg[k*REG_ID_BIT +: REG_ID_BIT] == REG_ID_BIT'(r)) begin
                        if (!busy[r]) begin
                            idle_hit_c = 1'b1;
                        end
                        busy_nxt_c[r] = 1'b0;
                    end
                end
            end
        end
        if (set_en) begin
            for (int r = 0; r < int'(NUM_REG); r++) begin
                if (set_reg == REG_ID_BIT'(r)) begin
                    busy_nxt_c[r] = 1'b1;
                end
            end
        end
    end

    // Busy state and sticky idle-writeback flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= '0;
            err_wb_idle <= 1'b0;
        end else begin
            busy        <= busy_nxt_c;
            err_wb_idle <= err_wb_idle | idle_hit_c;
        end
    end

endmodule

// File: rtl/dispatch_scoreboard.sv
// In-order dispatch scoreboard for a set of per-FU issue stations.
// Instructions are handed to their target station only when the destination
// has no outstanding write (WAW) and no station still has to read the old
// value (WAR). Source readiness is left to the stations via ready_reg_mask.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   in_vld/in_rdy     - instruction handshake (in_rdy is combinational)
//   in_*              - instruction fields and target station in_fu
//   st_vld/st_rdy     - per-station push handshake (st_vld is combinational)
//   st_*              - instruction fields broadcast to all stations
//   st_pending_read   - station k pending-read mask at [k*NUM_REG +: NUM_REG]
//   st_empty          - per-station empty flags
//   wb_vld/wb_reg     - per-FU writeback, FU k register at [k*REG_ID_BIT +: REG_ID_BIT]
//   ready_reg_mask    - registers with no outstanding write
//   drain_req         - request to drain the machine
//   drain_done        - one-cycle pulse when the drain has completed
//   err_bad_fu        - sticky: an instruction targeted a non-existent station
//   err_wb_idle       - sticky: a writeback named a non-busy register
//   stall_cnt         - saturating count of hazard/backpressure stall cycles
module dispatch_scoreboard
    import ooo_pkg::*;
#(
    parameter int unsigned NUM_STATION = DEF_NUM_STATION,
    parameter int unsigned NUM_REG     = DEF_NUM_REG,
    parameter int unsigned INST_ID_BIT = DEF_INST_ID_BIT,
    parameter int unsigned IMM_BIT     = DEF_IMM_BIT,
    parameter int unsigned REG_ID_BIT  = $clog2(NUM_REG),
    parameter int unsigned FU_ID_BIT   = clog2_min1(NUM_STATION)
) (
    input  logic                              clk,
    input  logic                              rst_n,

    input  logic                              in_vld,
    output logic                              in_rdy,
    input  logic [INST_ID_BIT-1:0]            in_id,
    input  logic [FU_ID_BIT-1:0]              in_fu,
    input  logic [REG_ID_BIT-1:0]             in_dst_reg,
    input  logic [REG_ID_BIT-1:0]             in_src_reg0,
    input  logic [REG_ID_BIT-1:0]             in_src_reg1,
    input  logic [IMM_BIT-1:0]                in_imm,

    output logic [NUM_STATION-1:0]            st_vld,
    input  logic [NUM_STATION-1:0]            st_rdy,
    output logic [INST_ID_BIT-1:0]            st_id,
    output logic [REG_ID_BIT-1:0]             st_dst_reg,
    output logic [REG_ID_BIT-1:0]             st_src_reg0,
    output logic [REG_ID_BIT-1:0]             st_src_reg1,
    output logic [IMM_BIT-1:0]                st_imm,
    input  logic [NUM_STATION*NUM_REG-1:0]    st_pending_read,
    input  logic [NUM_STATION-1:0]            st_empty,

    input  logic [NUM_STATION-1:0]            wb_vld,
    input  logic [NUM_STATION*REG_ID_BIT-1:0] wb_reg,

    output logic [NUM_REG-1:0]                ready_reg_mask,

    input  logic                              drain_req,
    output logic                              drain_done,

    output logic                              err_bad_fu,
    output logic                              err_wb_idle,
    output logic [STALL_CNT_BIT-1:0]          stall_cnt
);

    dsb_state_e              state;
    logic [NUM_REG-1:0]      busy;
    logic [NUM_REG-1:0]      pending_or_c;
    logic [NUM_STATION-1:0]  fu_sel_c;
    logic                    fu_valid_c;
    logic                    fu_rdy_c;
    logic                    waw_c;
    logic                    war_c;
    logic                    fire_c;
    logic                    set_en_c;

    reg_busy_table #(
        .NUM_REG    (NUM_REG),
        .NUM_WB     (NUM_STATION),
        .REG_ID_BIT (REG_ID_BIT)
    ) u_busy (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_en      (set_en_c),
        .set_reg     (in_dst_reg),
        .clr_vld     (wb_vld),
        .clr_reg     (wb_reg),
        .busy        (busy),
        .err_wb_idle (err_wb_idle)
    );

    // Registers some station still has to read.
    always_comb begin
        pending_or_c = '0;
        for (int k = 0; k < int'(NUM_STATION); k++) begin
            pending_or_c = pending_or_c | st_pending_read[k*NUM_REG +: NUM_REG];
        end
    end

    // Destination hazards, looked up without indexing past NUM_REG.
    always_comb begin
        waw_c = 1'b0;
        war_c = 1'b0;
        for (int r = 0; r < int'(NUM_REG); r++) begin
            if (in_dst_reg == REG_ID_BIT'(r)) begin
                waw_c = busy[r];
                war_c = pending_or_c[r];
            end
        end
    end

    // One-hot station select; all zero when in_fu names no station.
    always_comb begin
        fu_sel_c = '0;
        for (int k = 0; k < int'(NUM_STATION); k++) begin
            fu_sel_c[k] = (in_fu == FU_ID_BIT'(k));
        end
    end

    assign fu_valid_c = (32'(in_fu) < NUM_STATION);
    assign fu_rdy_c   = |(st_rdy & fu_sel_c);

    // Bad-FU instructions are always accepted so they can be discarded.
    assign in_rdy   = (state == ST_RUN) &&
                      (!fu_valid_c || (!(waw_c || war_c) && fu_rdy_c));
    assign fire_c   = in_vld && in_rdy;
    assign set_en_c = fire_c && fu_valid_c;

    assign st_vld      = fire_c ? fu_sel_c : '0;
    assign st_id       = in_id;
    assign st_dst_reg  = in_dst_reg;
    assign st_src_reg0 = in_src_reg0;
    assign st_src_reg1 = in_src_reg1;
    assign st_imm      = in_imm;

    assign ready_reg_mask = ~busy;

    // Drain FSM; drain_done is registered and high exactly while in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            drain_done <= 1'b0;
        end else begin
            drain_done <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (drain_req) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if ((busy == '0) && (&st_empty)) begin
                        state      <= ST_DONE;
                        drain_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // Sticky bad-FU flag and saturating stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_bad_fu <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            if (fire_c && !fu_valid_c) begin
                err_bad_fu <= 1'b1;
            end
            if (in_vld && (state == ST_RUN) && !in_rdy && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + STALL_CNT_BIT'(1);
            end
        end
    end

endmodule

// File: tb/tb_dispatch_scoreboard.sv
// Directed bench for dispatch_scoreboard: two stations, eight registers,
// in_fu widened to two bits so a non-existent station can be addressed.
module tb_dispatch_scoreboard;

    localparam int unsigned NS  = 2;
    localparam int unsigned NR  = 8;
    localparam int unsigned IDB = 8;
    localparam int unsigned IMB = 4;
    localparam int unsigned RB  = 3;
    localparam int unsigned FB  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_vld;
    logic              in_rdy;
    logic [IDB-1:0]    in_id;
    logic [FB-1:0]     in_fu;
    logic [RB-1:0]     in_dst_reg;
    logic [RB-1:0]     in_src_reg0;
    logic [RB-1:0]     in_src_reg1;
    logic [IMB-1:0]    in_imm;
    logic [NS-1:0]     st_vld;
    logic [NS-1:0]     st_rdy;
    logic [IDB-1:0]    st_id;
    logic [RB-1:0]     st_dst_reg;
    logic [RB-1:0]     st_src_reg0;
    logic [RB-1:0]     st_src_reg1;
    logic [IMB-1:0]    st_imm;
    logic [NS*NR-1:0]  st_pending_read;
    logic [NS-1:0]     st_empty;
    logic [NS-1:0]     wb_vld;
    logic [NS*RB-1:0]  wb_reg;
    logic [NR-1:0]     ready_reg_mask;
    logic              drain_req;
    logic              drain_done;
    logic              err_bad_fu;
    logic              err_wb_idle;
    logic [15:0]       stall_cnt;

    int n_checks  = 0;
    int n_fail    = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    dispatch_scoreboard #(
        .NUM_STATION (NS),
        .NUM_REG     (NR),
        .INST_ID_BIT (IDB),
        .IMM_BIT     (IMB),
        .REG_ID_BIT  (RB),
        .FU_ID_BIT   (FB)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_vld          (in_vld),
        .in_rdy          (in_rdy),
        .in_id           (in_id),
        .in_fu           (in_fu),
        .in_dst_reg      (in_dst_reg),
        .in_src_reg0     (in_src_reg0),
        .in_src_reg1     (in_src_reg1),
        .in_imm          (in_imm),
        .st_vld          (st_vld),
        .st_rdy          (st_rdy),
        .st_id           (st_id),
        .st_dst_reg      (st_dst_reg),
        .st_src_reg0     (st_src_reg0),
        .st_src_reg1     (st_src_reg1),
        .st_imm          (st_imm),
        .st_pending_read (st_pending_read),
        .st_empty        (st_empty),
        .wb_vld          (wb_vld),
        .wb_reg          (wb_reg),
        .ready_reg_mask  (ready_reg_mask),
        .drain_req       (drain_req),
        .drain_done      (drain_done),
        .err_bad_fu      (err_bad_fu),
        .err_wb_idle     (err_wb_idle),
        .stall_cnt       (stall_cnt)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_vld          = 1'b0;
        in_id           = '0;
        in_fu           = '0;
        in_dst_reg      = '0;
        in_src_reg0     = '0;
        in_src_reg1     = '0;
        in_imm          = '0;
        st_rdy          = 2'b11;
        st_pending_read = '0;
        st_empty        = 2'b11;
        wb_vld          = '0;
        wb_reg          = '0;
        drain_req       = 1'b0;
    endtask

    task automatic present(input logic [FB-1:0] fu, input logic [RB-1:0] dst,
                           input logic [IDB-1:0] id);
        in_vld      = 1'b1;
        in_fu       = fu;
        in_dst_reg  = dst;
        in_id       = id;
        in_src_reg0 = 3'd1;
        in_src_reg1 = 3'd6;
        in_imm      = 4'h5;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #2;
        n_checks++; if (ready_reg_mask !== 8'hFF) begin n_fail++; $display("FAIL reset_mask: got %h want ff", ready_reg_mask); end
        n_checks++; if (drain_done !== 1'b0) begin n_fail++; $display("FAIL reset_drain_done: got %b want 0", drain_done); end
        n_checks++; if ({err_bad_fu, err_wb_idle} !== 2'b00) begin n_fail++; $display("FAIL reset_errs: got %b want 00", {err_bad_fu, err_wb_idle}); end
        n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
        n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_in_rdy: got %b want 1", in_rdy); end
        #10;
        rst_n = 1'b1;
        tick();
    endtask

    // WAW: second writer to r3 waits until the cycle after the writeback edge.
    task automatic test_waw();
        present(2'd0, 3'd3, 8'h11);
        #1;
        n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL waw_first_rdy: got %b want 1", in_rdy); end
        n_checks++; if (st_vld !== 2'b01) begin n_fail++; $display("FAIL waw_first_st_vld: got %b want 01", st_vld); end
        n_checks++; if ({st_id, st_dst_reg, st_src_reg0, st_src_reg1, st_imm} !== {8'h11, 3'd3, 3'd1, 3'd6, 4'h5}) begin
            n_fail++; $display("FAIL waw_fields: got %h/%0d/%0d/%0d/%h want 11/3/1/6/5", st_id, st_dst_reg, st_src_reg0, st_src_reg1, st_imm);
        end
        tick();
        present(2'd1, 3'd3, 8'h12);
        #1;
        n_checks++; if (ready_reg_mask[3] !== 1'b0) begin n_fail++; $display("FAIL waw_busy: got %b want 0", ready_reg_mask[3]); end
        n_checks++; if (in_rdy !== 1'b0 || st_vld !== 2'b00) begin n_fail++; $display("FAIL waw_stall: got rdy=%b vld=%b want 0/00", in_rdy, st_vld); end
        tick();
        exp_stall++;
        wb_vld = 2'b01;
        wb_reg = {3'd0, 3'd3};
        #1;
        n_checks++; if (stall_cnt !== 16'(exp_stall)) begin n_fail++; $display("FAIL waw_stall_cnt1: got %0d want %0d", stall_cnt, exp_stall); end
        n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL waw_no_bypass: got %b want 0", in_rdy); end
        tick();
        exp_stall++;
        wb_vld = 2'b00;
        #1;
        n_checks++; if (ready_reg_mask[3] !== 1'b1) begin n_fail++; $display("FAIL waw_cleared: got %b want 1", ready_reg_mask[3]); end
        n_checks++; if (in_rdy !== 1'b1 || st_vld !== 2'b10) begin n_fail++; $display("FAIL waw_second_go: got rdy=%b vld=%b want 1/10", in_rdy, st_vld); end
        n_checks++; if (stall_cnt !== 16'(exp_stall)) begin n_fail++; $display("FAIL waw_stall_cnt2: got %0d want %0d", stall_cnt, exp_stall); end
        tick();
        in_vld = 1'b0;
        #1;
        n_checks++; if (ready_reg_mask[3] !== 1'b0) begin n_fail++; $display("FAIL waw_rebusy: got %b want 0", ready_reg_mask[3]); end
        wb_vld = 2'b10;
        wb_reg = {3'd3, 3'd0};
        tick();
        wb_vld = 2'b00;
        #1;
        n_checks++; if (ready_reg_mask !== 8'hFF) begin n_fail++; $display("FAIL waw_final_mask: got %h want ff", ready_reg_mask); end
        n_checks++; if (err_wb_idle !== 1'b0) begin n_fail++; $display("FAIL waw_no_idle_err: got %b want 0", err_wb_idle); end
    endtask

    // WAR: FU1 still reading r5 blocks a new writer of r5.
    task automatic test_war();
        st_pending_read = 16'h2000;
        present(2'd0, 3'd5, 8'h21);
        #1;
        n_checks++; if (in_rdy !== 1'b0 || st_vld !== 2'b00) begin n_fail++; $display("FAIL war_stall: got rdy=%b vld=%b want 0/00", in_rdy, st_vld); end
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_stall++;
            n_checks++; if (stall_cnt !== 16'(exp_stall)) begin n_fail++; $display("FAIL war_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
        end
        st_pending_read = '0;
        #1;
        n_checks++; if (in_rdy !== 1'b1 || st_vld !== 2'b01) begin n_fail++; $display("FAIL war_release: got rdy=%b vld=%b want 1/01", in_rdy, st_vld); end
        tick();
        in_vld = 1'b0;
        #1;
        n_checks++; if (ready_reg_mask[5] !== 1'b0) begin n_fail++; $display("FAIL war_busy: got %b want 0", ready_reg_mask[5]); end
        n_checks++; if (stall_cnt !== 16'(exp_stall)) begin n_fail++; $display("FAIL war_stall_hold: got %0d want %0d", stall_cnt, exp_stall); end
        wb_vld = 2'b01;
        wb_reg = {3'd0, 3'd5};
        tick();
        wb_vld = 2'b00;
        #1;
        n_checks++; if (ready_reg_mask !== 8'hFF) begin n_fail++; $display("FAIL war_final_mask: got %h want ff", ready_reg_mask); end
    endtask

    // Station backpressure: FU0 not ready stalls, FU1 ready dispatches at once.
    task automatic test_station_rdy();
        st_rdy = 2'b10;
        present(2'd0, 3'd4, 8'h31);
        #1;
        n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL strdy_stall: got %b want 0", in_rdy); end
        tick();
        exp_stall++;
        in_fu  = 2'd1;
        in_id  = 8'h32;
        in_imm = 4'hA;
        #1;
        n_checks++; if (in_rdy !== 1'b1 || st_vld !== 2'b10) begin n_fail++; $display("FAIL strdy_fu1: got rdy=%b vld=%b want 1/10", in_rdy, st_vld); end
        n_checks++; if (st_id !== 8'h32 || st_imm !== 4'hA) begin n_fail++; $display("FAIL strdy_fields: got %h/%h want 32/a", st_id, st_imm); end
        n_checks++; if (stall_cnt !== 16'(exp_stall)) begin n_fail++; $display("FAIL strdy_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
        tick();
        in_vld = 1'b0;
        st_rdy = 2'b11;
        #1;
        n_checks++; if (ready_reg_mask[4] !== 1'b0) begin n_fail++; $display("FAIL strdy_busy: got %b want 0", ready_reg_mask[4]); end
        wb_vld = 2'b10;
        wb_reg = {3'd4, 3'd0};
        tick();
        wb_vld = 2'b00;
        #1;
        n_checks++; if (ready_reg_mask !== 8'hFF) begin n_fail++; $display("FAIL strdy_final_mask: got %h want ff", ready_reg_mask); end
    endtask

    // Non-existent station and writeback to an idle register.
    task automatic test_bad_fu();
        present(2'd3, 3'd6, 8'h41);
        #1;
        n_checks++; if (in_rdy !== 1'b1 || st_vld !== 2'b00) begin n_fail++; $display("FAIL badfu_consume: got rdy=%b vld=%b want 1/00", in_rdy, st_vld); end
        tick();
        in_vld = 1'b0;
        #1;
        n_checks++; if (err_bad_fu !== 1'b1) begin n_fail++; $display("FAIL badfu_flag: got %b want 1", err_bad_fu); end
        n_checks++; if (ready_reg_mask !== 8'hFF) begin n_fail++; $display("FAIL badfu_mask: got %h want ff", ready_reg_mask); end
        tick();
        n_checks++; if (err_bad_fu !== 1'b1) begin n_fail++; $display("FAIL badfu_sticky: got %b want 1", err_bad_fu); end
        n_checks++; if (err_wb_idle !== 1'b0) begin n_fail++; $display("FAIL wbidle_pre: got %b want 0", err_wb_idle); end
        wb_vld = 2'b01;
        wb_reg = {3'd0, 3'd7};
        tick();
        wb_vld = 2'b00;
        #1;
        n_checks++; if (err_wb_idle !== 1'b1) begin n_fail++; $display("FAIL wbidle_flag: got %b want 1", err_wb_idle); end
        n_checks++; if (ready_reg_mask !== 8'hFF) begin n_fail++; $display("FAIL wbidle_mask: got %h want ff", ready_reg_mask); end
    endtask

    // Dispatch and writeback of the same register in one cycle leaves it busy.
    task automatic test_set_over_clear();
        present(2'd0, 3'd2, 8'h51);
        wb_vld = 2'b01;
        wb_reg = {3'd0, 3'd2};
        #1;
        n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL setclr_rdy: got %b want 1", in_rdy); end
        tick();
        in_vld = 1'b0;
        wb_vld = 2'b00;
        #1;
        n_checks++; if (ready_reg_mask[2] !== 1'b0) begin n_fail++; $display("FAIL setclr_set_wins: got %b want 0", ready_reg_mask[2]); end
        wb_vld = 2'b01;
        wb_reg = {3'd0, 3'd2};
        tick();
        wb_vld = 2'b00;
        #1;
        n_checks++; if (ready_reg_mask !== 8'hFF) begin n_fail++; $display("FAIL setclr_final_mask: got %h want ff", ready_reg_mask); end
    endtask

    // Drain with r1/r2 outstanding, double writeback, then the done pulse.
    task automatic test_drain();
        present(2'd0, 3'd1, 8'h61);
        tick();
        present(2'd1, 3'd2, 8'h62);
        #1;
        n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL drain_disp2_rdy: got %b want 1", in_rdy); end
        tick();
        in_vld = 1'b0;
        #1;
        n_checks++; if (ready_reg_mask !== 8'hF9) begin n_fail++; $display("FAIL drain_busy_mask: got %h want f9", ready_reg_mask); end
        st_empty  = 2'b01;
        drain_req = 1'b1;
        tick();
        drain_req = 1'b0;
        present(2'd0, 3'd0, 8'h63);
        #1;
        n_checks++; if (in_rdy !== 1'b0 || st_vld !== 2'b00) begin n_fail++; $display("FAIL drain_block: got rdy=%b vld=%b want 0/00", in_rdy, st_vld); end
        tick();
        in_vld = 1'b0;
        n_checks++; if (stall_cnt !== 16'(exp_stall)) begin n_fail++; $display("FAIL drain_no_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
        wb_vld = 2'b11;
        wb_reg = {3'd2, 3'd1};
        tick();
        wb_vld = 2'b00;
        #1;
        n_checks++; if (ready_reg_mask !== 8'hFF) begin n_fail++; $display("FAIL drain_dual_wb: got %h want ff", ready_reg_mask); end
        tick();
        n_checks++; if (drain_done !== 1'b0 || in_rdy !== 1'b0) begin n_fail++; $display("FAIL drain_wait_empty: got done=%b rdy=%b want 0/0", drain_done, in_rdy); end
        st_empty = 2'b11;
        tick();
        n_checks++; if (drain_done !== 1'b1 || in_rdy !== 1'b0) begin n_fail++; $display("FAIL drain_done_pulse: got done=%b rdy=%b want 1/0", drain_done, in_rdy); end
        tick();
        n_checks++; if (drain_done !== 1'b0 || in_rdy !== 1'b1) begin n_fail++; $display("FAIL drain_back_run: got done=%b rdy=%b want 0/1", drain_done, in_rdy); end
    endtask

    // Asynchronous reset while draining clears all tracking immediately.
    task automatic test_reset_mid_drain();
        present(2'd0, 3'd6, 8'h71);
        tick();
        in_vld    = 1'b0;
        st_empty  = 2'b10;
        drain_req = 1'b1;
        tick();
        drain_req = 1'b0;
        n_checks++; if (in_rdy !== 1'b0 || ready_reg_mask[6] !== 1'b0) begin n_fail++; $display("FAIL rstdrain_pre: got rdy=%b mask6=%b want 0/0", in_rdy, ready_reg_mask[6]); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (ready_reg_mask !== 8'hFF) begin n_fail++; $display("FAIL rstdrain_mask: got %h want ff", ready_reg_mask); end
        n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rstdrain_stall: got %0d want 0", stall_cnt); end
        n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL rstdrain_run: got %b want 1", in_rdy); end
        n_checks++; if ({err_bad_fu, err_wb_idle, drain_done} !== 3'b000) begin n_fail++; $display("FAIL rstdrain_flags: got %b want 000", {err_bad_fu, err_wb_idle, drain_done}); end
        #2;
        rst_n    = 1'b1;
        st_empty = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (drain_done !== 1'b0 || ready_reg_mask !== 8'hFF) begin n_fail++; $display("FAIL rstdrain_after: got done=%b mask=%h want 0/ff", drain_done, ready_reg_mask); end
        end
    endtask

    initial begin
        test_reset();
        test_waw();
        test_war();
        test_station_rdy();
        test_bad_fu();
        test_set_over_clear();
        test_drain();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
